// File: rtl/vote_collector.sv
// Timed four-voter ballot collector with a valid/ready ballot output.
// Optional build macro VOTE_LOCK_EN makes each voter's first accepted cast final.
module vote_collector #(
  parameter int WINDOW_CYCLES = 1000,
  parameter int TMR_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] vote_yes,
  input  logic [3:0] vote_no,
  input  logic       ballot_ready,
  output logic [3:0] ballot,
  output logic       ballot_valid,
  output logic [3:0] cast_mask,
  output logic       busy,
  output logic       timed_out
);

  localparam logic [1:0]       ST_IDLE  = 2'd0;
  localparam logic [1:0]       ST_OPEN  = 2'd1;
  localparam logic [1:0]       ST_DONE  = 2'd2;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(WINDOW_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_ZERO = TMR_W'(0);

  logic [1:0]       state_r;
  logic [TMR_W-1:0] timer_r;
  logic [3:0]       yes_acc_s;
  logic [3:0]       no_acc_s;
  logic [3:0]       next_mask_s;
  logic [3:0]       next_ballot_s;
  logic             all_cast_s;

  // Accepted casts this cycle and the resulting mask/ballot; a yes+no collision is dropped.
  always_comb begin
    yes_acc_s     = 4'b0000;
    no_acc_s      = 4'b0000;
    next_mask_s   = cast_mask;
    next_ballot_s = ballot;
    all_cast_s    = 1'b0;
`ifdef VOTE_LOCK_EN
    yes_acc_s = vote_yes & ~vote_no & ~cast_mask;
    no_acc_s  = vote_no & ~vote_yes & ~cast_mask;
`else
    yes_acc_s = vote_yes & ~vote_no;
    no_acc_s  = vote_no & ~vote_yes;
`endif
    next_mask_s   = cast_mask | yes_acc_s | no_acc_s;
    next_ballot_s = (ballot | yes_acc_s) & ~no_acc_s;
    if (next_mask_s == 4'b1111) begin
      all_cast_s = 1'b1;
    end else begin
      all_cast_s = 1'b0;
    end
  end

  // Session FSM, window timer and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      timer_r      <= TMR_ZERO;
      ballot       <= 4'b0000;
      cast_mask    <= 4'b0000;
      ballot_valid <= 1'b0;
      busy         <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r   <= ST_OPEN;
            busy      <= 1'b1;
            ballot    <= 4'b0000;
            cast_mask <= 4'b0000;
            timed_out <= 1'b0;
            timer_r   <= TMR_LOAD;
          end
        end
        ST_OPEN: begin
          ballot    <= next_ballot_s;
          cast_mask <= next_mask_s;
          // A full mask wins over expiry on the same final cycle.
          if (all_cast_s) begin
            state_r      <= ST_DONE;
            ballot_valid <= 1'b1;
            timed_out    <= 1'b0;
          end else if (timer_r == TMR_ZERO) begin
            state_r      <= ST_DONE;
            ballot_valid <= 1'b1;
            timed_out    <= 1'b1;
          end else begin
            timer_r <= timer_r - TMR_ONE;
          end
        end
        ST_DONE: begin
          if (ballot_ready) begin
            state_r      <= ST_IDLE;
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          ballot_valid <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_collector.sv
// Randomized bench for vote_collector with a per-session outcome model
// computed from the cast rules over a whole session schedule.
module tb_vote_collector;

  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] vote_yes = 4'b0000;
  logic [3:0] vote_no = 4'b0000;
  logic       ballot_ready = 1'b0;
  logic [3:0] ballot;
  logic       ballot_valid;
  logic [3:0] cast_mask;
  logic       busy;
  logic       timed_out;

  int checks = 0;
  int failures = 0;

  logic [3:0] sched_yes [W];
  logic [3:0] sched_no  [W];

  vote_collector #(.WINDOW_CYCLES(W), .TMR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_yes(vote_yes), .vote_no(vote_no),
    .ballot_ready(ballot_ready), .ballot(ballot), .ballot_valid(ballot_valid),
    .cast_mask(cast_mask), .busy(busy), .timed_out(timed_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_sched();
    for (int c = 0; c < W; c++) begin
      sched_yes[c] = 4'b0000;
      sched_no[c]  = 4'b0000;
    end
  endtask

  task automatic random_sched();
    for (int c = 0; c < W; c++) begin
      sched_yes[c] = 4'b0000;
      sched_no[c]  = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 11))
          0: sched_yes[c][i] = 1'b1;
          1: sched_no[c][i] = 1'b1;
          2: begin sched_yes[c][i] = 1'b1; sched_no[c][i] = 1'b1; end
          default: ;
        endcase
      end
    end
  endtask

  // Runs one full session from IDLE using the current schedule, then holds DONE for `hold` cycles.
  task automatic run_session(input string name, input int hold);
    int         close_c;
    logic [3:0] eb;
    logic [3:0] em;
    logic       eto;
    logic       done;
    // Outcome model: walk the schedule with the cast rules; session ends on full mask or window end.
    eb = 4'b0000; em = 4'b0000; eto = 1'b1; close_c = W - 1; done = 1'b0;
    for (int c = 0; c < W; c++) begin
      if (!done) begin
        for (int i = 0; i < 4; i++) begin
          if (sched_yes[c][i] != sched_no[c][i]) begin
`ifdef VOTE_LOCK_EN
            if (!em[i]) begin eb[i] = sched_yes[c][i]; em[i] = 1'b1; end
`else
            eb[i] = sched_yes[c][i]; em[i] = 1'b1;
`endif
          end
        end
        if (em == 4'b1111) begin close_c = c; eto = 1'b0; done = 1'b1; end
      end
    end

    start = 1'b1; vote_yes = 4'($urandom); vote_no = 4'($urandom); ballot_ready = 1'b0;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, cast_mask, ballot, timed_out, ballot_valid} !== {1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL %s_open: busy/mask/ballot/to/valid=%b required=%b", name,
               {busy, cast_mask, ballot, timed_out, ballot_valid}, {1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
    end
    for (int c = 0; c <= close_c; c++) begin
      vote_yes = sched_yes[c]; vote_no = sched_no[c]; start = 1'($urandom);
      tick();
      checks++;
      if (c < close_c) begin
        if ({ballot_valid, busy} !== 2'b01) begin
          failures++;
          $display("FAIL %s_early_valid cycle %0d: valid/busy=%b required=01", name, c, {ballot_valid, busy});
        end
      end else begin
        if ({ballot_valid, ballot, cast_mask, timed_out, busy} !== {1'b1, eb, em, eto, 1'b1}) begin
          failures++;
          $display("FAIL %s_close cycle %0d: valid/ballot/mask/to/busy=%b required=%b", name, c,
                   {ballot_valid, ballot, cast_mask, timed_out, busy}, {1'b1, eb, em, eto, 1'b1});
        end
      end
    end
    vote_yes = 4'b0000; vote_no = 4'b0000; start = 1'b0;
    for (int h = 0; h < hold; h++) begin
      vote_yes = 4'($urandom); vote_no = 4'($urandom); start = (h == hold / 2);
      tick();
      checks++;
      if ({ballot_valid, ballot, cast_mask, timed_out, busy} !== {1'b1, eb, em, eto, 1'b1}) begin
        failures++;
        $display("FAIL %s_hold %0d: valid/ballot/mask/to/busy=%b required=%b", name, h,
                 {ballot_valid, ballot, cast_mask, timed_out, busy}, {1'b1, eb, em, eto, 1'b1});
      end
    end
    vote_yes = 4'b0000; vote_no = 4'b0000; start = 1'b0; ballot_ready = 1'b1;
    tick();
    ballot_ready = 1'b0;
    checks++;
    if ({ballot_valid, busy, ballot, cast_mask} !== {1'b0, 1'b0, eb, em}) begin
      failures++;
      $display("FAIL %s_release: valid/busy/ballot/mask=%b required=%b", name,
               {ballot_valid, busy, ballot, cast_mask}, {1'b0, 1'b0, eb, em});
    end
    vote_yes = 4'($urandom); vote_no = 4'($urandom);
    tick();
    vote_yes = 4'b0000; vote_no = 4'b0000;
    checks++;
    if ({ballot_valid, busy, ballot, cast_mask} !== {1'b0, 1'b0, eb, em}) begin
      failures++;
      $display("FAIL %s_idle_cast: valid/busy/ballot/mask=%b required=%b", name,
               {ballot_valid, busy, ballot, cast_mask}, {1'b0, 1'b0, eb, em});
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ballot, ballot_valid, cast_mask, busy, timed_out} !== 11'd0) begin
      failures++;
      $display("FAIL reset_async: outputs=%b required=%b", {ballot, ballot_valid, cast_mask, busy, timed_out}, 11'd0);
    end
    start = 1'b1; vote_yes = 4'b1111;
    tick(); tick();
    checks++;
    if ({ballot, ballot_valid, cast_mask, busy, timed_out} !== 11'd0) begin
      failures++;
      $display("FAIL reset_held: outputs=%b required=%b", {ballot, ballot_valid, cast_mask, busy, timed_out}, 11'd0);
    end
    start = 1'b0; vote_yes = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    clear_sched();
    sched_yes[0] = 4'b0001; sched_yes[1] = 4'b0010; sched_yes[2] = 4'b0100; sched_no[3] = 4'b1000;
    run_session("early_close", 0);
    clear_sched();
    sched_yes[2] = 4'b0001;
    run_session("timeout", 0);
    clear_sched();
    sched_yes[1] = 4'b0010; sched_no[4] = 4'b0010;
    run_session("recast", 0);
    clear_sched();
    sched_yes[3] = 4'b0100; sched_no[3] = 4'b0100;
    run_session("collision", 1);
    clear_sched();
    sched_no[W-1] = 4'b1111;
    run_session("last_cycle_full", 0);
  endtask

  task automatic test_back_pressure();
    clear_sched();
    sched_yes[0] = 4'b0001; sched_yes[1] = 4'b0010; sched_yes[2] = 4'b0100; sched_no[3] = 4'b1000;
    run_session("hold_ready", 10);
  endtask

  task automatic test_mid_reset();
    start = 1'b1;
    tick();
    start = 1'b0; vote_yes = 4'b0011;
    tick();
    vote_yes = 4'b0000;
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, cast_mask, ballot, timed_out, ballot_valid} !== 11'd0) begin
      failures++;
      $display("FAIL mid_reset: busy/mask/ballot/to/valid=%b required=%b",
               {busy, cast_mask, ballot, timed_out, ballot_valid}, 11'd0);
    end
    #2 rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      tick();
      checks++;
      if ({ballot_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL mid_reset_quiet %0d: valid/busy=%b required=00", k, {ballot_valid, busy});
      end
    end
    random_sched();
    run_session("after_reset", 1);
  endtask

  task automatic test_random();
    for (int s = 0; s < 30; s++) begin
      random_sched();
      run_session($sformatf("rand%0d", s), $urandom_range(0, 3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_pressure();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
